// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control sequencer.
// Steps the shared datapath through IF/ID/EX/MEM/WB.
module mc_control_fsm #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [6:0]        opcode,
  input  logic              bcond,
  input  logic              mem_ready,
  input  logic              ecall_halt,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_ctrl_sel,
  output logic              i_or_d,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_write,
  output logic              pc_write,
  output logic              wb_sel,
  output logic              pc_source,
  output logic              halted,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] retired_count
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] SEL_ADD = 2'd0;
  localparam logic [1:0] SEL_FN  = 2'd1;
  localparam logic [1:0] SEL_BR  = 2'd2;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t cur_q;
  state_t nxt;

  logic is_arith;
  logic is_arith_imm;
  logic is_load;
  logic is_store;
  logic is_branch;
  logic is_jal;
  logic is_jalr;
  logic is_ecall;
  logic is_known;
  logic retire;

  assign is_arith     = (opcode == OP_ARITH);
  assign is_arith_imm = (opcode == OP_ARITH_IMM);
  assign is_load      = (opcode == OP_LOAD);
  assign is_store     = (opcode == OP_STORE);
  assign is_branch    = (opcode == OP_BRANCH);
  assign is_jal       = (opcode == OP_JAL);
  assign is_jalr      = (opcode == OP_JALR);
  assign is_ecall     = (opcode == OP_ECALL);

  assign is_known = is_arith | is_arith_imm
                  | is_load | is_store
                  | is_branch | is_jal
                  | is_jalr | is_ecall;

  assign state  = cur_q;
  assign retire = (nxt == S_IF) && (cur_q != S_IF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q         <= S_IF;
      retired_count <= '0;
    end else begin
      cur_q <= nxt;
      if (retire)
        retired_count <= retired_count + ADDR_W'(1);
    end
  end

  always_comb begin
    nxt          = cur_q;
    alu_src_a    = 1'b0;
    alu_src_b    = B_RS2;
    alu_ctrl_sel = SEL_ADD;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    wb_sel       = 1'b0;
    pc_source    = 1'b0;
    halted       = 1'b0;

    unique case (cur_q)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready)
          nxt = S_ID;
      end

      S_ID: begin
        alu_src_b = B_FOUR;
        if (is_ecall)
          nxt = ecall_halt ? S_HALT : S_WB;
        else if (!is_known)
          nxt = S_HALT;
        else
          nxt = S_EX;
      end

      S_EX: begin
        unique case (1'b1)
          is_arith: begin
            alu_src_a    = 1'b1;
            alu_ctrl_sel = SEL_FN;
            nxt          = S_WB;
          end
          is_arith_imm: begin
            alu_src_a    = 1'b1;
            alu_src_b    = B_IMM;
            alu_ctrl_sel = SEL_FN;
            nxt          = S_WB;
          end
          is_load, is_store: begin
            alu_src_a = 1'b1;
            alu_src_b = B_IMM;
            nxt       = S_MEM;
          end
          is_branch: begin
            alu_src_a    = 1'b1;
            alu_ctrl_sel = SEL_BR;
            if (bcond) begin
              nxt = S_BR;
            end else begin
              pc_write  = 1'b1;
              pc_source = 1'b1;
              nxt       = S_IF;
            end
          end
          is_jal, is_jalr: begin
            alu_src_a = is_jalr;
            alu_src_b = B_IMM;
            reg_write = 1'b1;
            pc_write  = 1'b1;
            nxt       = S_IF;
          end
          default: nxt = S_HALT;
        endcase
      end

      S_BR: begin
        alu_src_b = B_IMM;
        pc_write  = 1'b1;
        nxt       = S_IF;
      end

      // Operands held so ALUOut keeps the address across stalls
      S_MEM: begin
        i_or_d    = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = B_IMM;
        mem_read  = is_load;
        mem_write = is_store;
        if (mem_ready)
          nxt = S_WB;
      end

      S_WB: begin
        alu_src_b = B_FOUR;
        pc_write  = 1'b1;
        reg_write = is_arith | is_arith_imm | is_load;
        wb_sel    = is_load;
        nxt       = S_IF;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: nxt = S_IF;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-cycle trace model
// built from instruction class and memory stall counts.
module tb_mc_control_fsm;

  localparam logic [6:0] ADD_OP  = 7'h33;
  localparam logic [6:0] ADDI_OP = 7'h13;
  localparam logic [6:0] LW_OP   = 7'h03;
  localparam logic [6:0] SW_OP   = 7'h23;
  localparam logic [6:0] BEQ_OP  = 7'h63;
  localparam logic [6:0] JAL_OP  = 7'h6F;
  localparam logic [6:0] JALR_OP = 7'h67;
  localparam logic [6:0] ECL_OP  = 7'h73;
  localparam logic [6:0] LUI_OP  = 7'h37;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  opcode;
  logic        bcond;
  logic        mem_ready;
  logic        ecall_halt;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_ctrl_sel;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic        pc_write;
  logic        wb_sel;
  logic        pc_source;
  logic        halted;
  logic [2:0]  state;
  logic [31:0] retired_count;

  mc_control_fsm #(.ADDR_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .bcond         (bcond),
    .mem_ready     (mem_ready),
    .ecall_halt    (ecall_halt),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_ctrl_sel  (alu_ctrl_sel),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .pc_write      (pc_write),
    .wb_sel        (wb_sel),
    .pc_source     (pc_source),
    .halted        (halted),
    .state         (state),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic        bc;
    logic        eh;
    logic        mr_in;
    logic [2:0]  st;
    logic        a;
    logic [1:0]  b;
    logic [1:0]  sel;
    logic        iod;
    logic        mrd;
    logic        mwr;
    logic        irw;
    logic        rw;
    logic        pcw;
    logic        wbs;
    logic        pcs;
    logic        hlt;
    logic [31:0] cnt;
  } rec_t;

  rec_t        q[$];
  rec_t        cur;
  bit          chk_en = 0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] exp_cnt = 0;

  function automatic logic [16:0] pk(rec_t r);
    return {r.st, r.a, r.b, r.sel, r.iod, r.mrd, r.mwr,
            r.irw, r.rw, r.pcw, r.wbs, r.pcs, r.hlt};
  endfunction

  function automatic rec_t blank(logic [6:0] op, logic bc,
                                 logic eh, logic [2:0] st);
    rec_t r;
    r.op = op; r.bc = bc; r.eh = eh;
    r.mr_in = 1'($urandom_range(0, 1));
    r.st = st; r.a = 0; r.b = 0; r.sel = 0;
    r.iod = 0; r.mrd = 0; r.mwr = 0; r.irw = 0;
    r.rw = 0; r.pcw = 0; r.wbs = 0; r.pcs = 0;
    r.hlt = 0; r.cnt = exp_cnt;
    return r;
  endfunction

  // Expected cycle trace for one instruction
  task automatic plan(input logic [6:0] op, input logic bc,
                      input logic eh, input int if_w,
                      input int mem_w, input int halt_n);
    rec_t r;
    bit   stop;
    bit   ld;
    bit   wb;
    stop = 0;
    wb = 0;
    ld = (op == LW_OP);
    for (int i = 0; i <= if_w; i++) begin
      r = blank(op, bc, eh, 3'd0);
      r.mr_in = (i == if_w);
      r.mrd = 1; r.irw = r.mr_in;
      q.push_back(r);
    end
    r = blank(op, bc, eh, 3'd1);
    r.b = 2;
    q.push_back(r);
    case (op)
      ADD_OP, ADDI_OP: begin
        r = blank(op, bc, eh, 3'd2);
        r.a = 1; r.b = (op == ADDI_OP) ? 2'd1 : 2'd0;
        r.sel = 1;
        q.push_back(r);
        wb = 1;
      end
      LW_OP, SW_OP: begin
        r = blank(op, bc, eh, 3'd2);
        r.a = 1; r.b = 1;
        q.push_back(r);
        for (int i = 0; i <= mem_w; i++) begin
          r = blank(op, bc, eh, 3'd3);
          r.a = 1; r.b = 1; r.iod = 1;
          r.mrd = ld; r.mwr = !ld;
          r.mr_in = (i == mem_w);
          q.push_back(r);
        end
        wb = 1;
      end
      BEQ_OP: begin
        r = blank(op, bc, eh, 3'd2);
        r.a = 1; r.sel = 2;
        r.pcw = !bc; r.pcs = !bc;
        q.push_back(r);
        if (bc) begin
          r = blank(op, bc, eh, 3'd5);
          r.b = 1; r.pcw = 1;
          q.push_back(r);
        end
      end
      JAL_OP, JALR_OP: begin
        r = blank(op, bc, eh, 3'd2);
        r.a = (op == JALR_OP); r.b = 1;
        r.rw = 1; r.pcw = 1;
        q.push_back(r);
      end
      ECL_OP: begin
        if (eh) stop = 1;
        else wb = 1;
      end
      default: stop = 1;
    endcase
    if (wb) begin
      r = blank(op, bc, eh, 3'd4);
      r.b = 2; r.pcw = 1;
      r.rw = (op == ADD_OP) || (op == ADDI_OP) || ld;
      r.wbs = ld;
      q.push_back(r);
    end
    if (stop) begin
      for (int i = 0; i < halt_n; i++) begin
        r = blank(op, bc, eh, 3'd6);
        r.hlt = 1;
        q.push_back(r);
      end
    end else begin
      exp_cnt = exp_cnt + 1;
    end
  endtask

  task automatic run_n(input int n);
    rec_t r;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      r = q.pop_front();
      opcode = r.op;
      bcond = r.bc;
      ecall_halt = r.eh;
      mem_ready = r.mr_in;
      cur = r;
      chk_en = 1;
      @(posedge clk);
      #1;
    end
    chk_en = 0;
  endtask

  task automatic run_all();
    run_n(q.size());
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    chk_en = 0;
    mem_ready = 0;
    reset_n = 0;
    #3;
    reset_n = 1;
    exp_cnt = 0;
    q.delete();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      checks++;
      if ({state, alu_src_a, alu_src_b, alu_ctrl_sel, i_or_d,
           mem_read, mem_write, ir_write, reg_write, pc_write,
           wb_sel, pc_source, halted} !== pk(cur)) begin
        failures++;
        $display("FAIL cyc%0d outs got=%h exp=%h op=%h", cyc,
          {state, alu_src_a, alu_src_b, alu_ctrl_sel, i_or_d,
           mem_read, mem_write, ir_write, reg_write, pc_write,
           wb_sel, pc_source, halted}, pk(cur), cur.op);
      end
      checks++;
      if (retired_count !== cur.cnt) begin
        failures++;
        $display("FAIL cyc%0d count got=%0d exp=%0d", cyc,
                 retired_count, cur.cnt);
      end
    end
  end

  initial begin
    reset_n = 0;
    opcode = ADD_OP;
    bcond = 0;
    ecall_halt = 0;
    mem_ready = 0;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_mem_read", 32'(mem_read), 1);
    chk("rst_iod", 32'(i_or_d), 0);
    chk("rst_strobes", 32'({ir_write, reg_write, pc_write,
                            mem_write, halted}), 0);
    chk("rst_count", retired_count, 0);
    @(posedge clk);
    #1;
    do_reset();

    plan(ADD_OP, 0, 0, 0, 0, 0);
    chk("len_add", 32'(q.size()), 4);
    run_all();
    chk("add_retired", retired_count, 1);

    plan(LW_OP, 0, 0, 0, 3, 0);
    chk("len_lw_stall", 32'(q.size()), 8);
    run_all();

    plan(ADDI_OP, 0, 0, 2, 0, 0);
    chk("len_addi_ifw", 32'(q.size()), 6);
    run_all();

    plan(BEQ_OP, 0, 0, 0, 0, 0);
    chk("len_beq_nt", 32'(q.size()), 3);
    run_all();

    plan(BEQ_OP, 1, 0, 0, 0, 0);
    chk("len_beq_t", 32'(q.size()), 4);
    run_all();

    plan(JAL_OP, 0, 0, 0, 0, 0);
    chk("len_jal", 32'(q.size()), 3);
    run_all();
    chk("jal_retired", retired_count, 6);

    plan(JALR_OP, 1, 1, 0, 0, 0);
    run_all();

    plan(SW_OP, 0, 0, 0, 0, 0);
    chk("len_sw", 32'(q.size()), 5);
    run_all();

    plan(ECL_OP, 0, 0, 0, 0, 0);
    chk("len_ecall", 32'(q.size()), 3);
    run_all();
    chk("ecall_retired", retired_count, 9);

    plan(ECL_OP, 0, 1, 0, 0, 100);
    chk("len_halt", 32'(q.size()), 102);
    run_all();
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_count", retired_count, 9);

    do_reset();
    chk("post_halt_state", 32'(state), 0);
    plan(ADD_OP, 0, 0, 0, 0, 0);
    run_all();
    chk("pre_store_cnt", retired_count, 1);

    plan(SW_OP, 0, 0, 0, 3, 0);
    run_n(3);
    mem_ready = 0;
    #1;
    chk("sw_mem_state", 32'(state), 3);
    chk("sw_mem_write", 32'(mem_write), 1);
    #1;
    reset_n = 0;
    #1;
    chk("arst_mem_write", 32'(mem_write), 0);
    chk("arst_state", 32'(state), 0);
    chk("arst_mem_read", 32'(mem_read), 1);
    chk("arst_count", retired_count, 0);
    do_reset();

    plan(LUI_OP, 0, 0, 1, 0, 5);
    chk("len_undef", 32'(q.size()), 8);
    run_all();
    chk("undef_halted", 32'(halted), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
